i2c_write_engine: RTL and testbench

- Bit-level I2C master that serialises one 24-bit write (slave address byte + two data bytes) onto the I2C bus.
- Directly downstream of the codec/AV configuration sequencer, which supplies I2C_DATA/GO and consumes END/ACK.
- Runs on the system clock and generates SCL internally from a quarter-period tick, so no derived clock domain is needed.
- Write-only, single master, no clock stretching, no repeated start.

---
 rtl/i2c_write_engine.sv | 170 +++++++++++++++++
 tb/tb_i2c_write_engine.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_write_engine.sv
// Bit-level I2C write master: START, three bytes each followed by an ack slot, then STOP.
// SCL is produced from a quarter-bit tick, so the whole engine runs on CLK alone.
module i2c_write_engine #(
    parameter int CLK_FREQ = 50000000,
    parameter int I2C_FREQ = 20000,
    parameter int DIV      = CLK_FREQ / (4 * I2C_FREQ)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [23:0] I2C_DATA,
    input  logic        GO,
    output logic        END,
    output logic        ACK,
    output logic        BUSY,
    output logic        I2C_SCLK,
    inout  wire         I2C_SDAT
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_BIT   = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [3:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [23:0]   shift_q, shift_d;
    logic          scl_q, scl_d;
    logic          sda_oe_q, sda_oe_d;
    logic          end_q, end_d;
    logic          ack_q, ack_d;
    logic          busy_q, busy_d;
    logic          tick;
    logic          ack_slot;

    assign tick     = (state_q != S_IDLE) && (cnt_q == CW'(DIV - 1));
    assign ack_slot = (bit_q == 4'd8);

    // Open-drain SDA: only ever pulled low.
    assign I2C_SDAT = sda_oe_q ? 1'b0 : 1'bz;
    assign I2C_SCLK = scl_q;
    assign END      = end_q;
    assign ACK      = ack_q;
    assign BUSY     = busy_q;

    always_comb begin
        state_d  = state_q;
        qtr_d    = qtr_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        shift_d  = shift_q;
        scl_d    = scl_q;
        sda_oe_d = sda_oe_q;
        end_d    = end_q;
        ack_d    = ack_q;
        busy_d   = busy_q;

        // Counter stays at 0 in IDLE so the first tick lands DIV cycles after acceptance.
        if (state_q == S_IDLE || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (GO && !end_q) begin
                    shift_d = I2C_DATA;
                    ack_d   = 1'b0;
                    busy_d  = 1'b1;
                    qtr_d   = 2'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (qtr_q == 2'd0) begin
                        sda_oe_d = 1'b1;
                        qtr_d    = 2'd1;
                    end else begin
                        scl_d   = 1'b0;
                        qtr_d   = 2'd0;
                        bit_d   = 4'd0;
                        byte_d  = 2'd0;
                        state_d = S_BIT;
                    end
                end
            end
            S_BIT: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    case (qtr_q)
                        2'd0: sda_oe_d = ack_slot ? 1'b0 : ~shift_q[23];
                        2'd1: scl_d = 1'b1;
                        2'd2: if (ack_slot) ack_d = ack_q | I2C_SDAT;
                        default: begin
                            scl_d = 1'b0;
                            if (ack_slot) begin
                                bit_d = 4'd0;
                                if (byte_q == 2'd2) begin
                                    state_d = S_STOP;
                                end else begin
                                    byte_d = byte_q + 2'd1;
                                end
                            end else begin
                                shift_d = {shift_q[22:0], 1'b0};
                                bit_d   = bit_q + 4'd1;
                            end
                        end
                    endcase
                end
            end
            S_STOP: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    case (qtr_q)
                        2'd0: sda_oe_d = 1'b1;
                        2'd1: scl_d = 1'b1;
                        default: begin
                            sda_oe_d = 1'b0;
                            end_d    = 1'b1;
                            busy_d   = 1'b0;
                            qtr_d    = 2'd0;
                            state_d  = S_DONE;
                        end
                    endcase
                end
            end
            S_DONE: begin
                if (!GO) begin
                    end_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            qtr_q    <= 2'd0;
            bit_q    <= 4'd0;
            byte_q   <= 2'd0;
            shift_q  <= 24'd0;
            scl_q    <= 1'b1;
            sda_oe_q <= 1'b0;
            end_q    <= 1'b0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            qtr_q    <= qtr_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            shift_q  <= shift_d;
            scl_q    <= scl_d;
            sda_oe_q <= sda_oe_d;
            end_q    <= end_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
        end
    end
endmodule

// File: tb/tb_i2c_write_engine.sv
// Directed bench for i2c_write_engine: slave model plus bus decoder feeding a scoreboard
// that checks each completed transaction when END rises.
module tb_i2c_write_engine;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic [23:0] data = 24'd0;
    logic        end_o, ack_o, busy_o, scl_o;
    wire         sda_w;
    logic        slave_drive = 1'b0;
    logic [2:0]  nack_mask = 3'b000;

    pullup (sda_w);
    assign sda_w = slave_drive ? 1'b0 : 1'bz;

    i2c_write_engine #(.CLK_FREQ(400), .I2C_FREQ(25)) dut (
        .CLK(clk), .RST(rst_n), .I2C_DATA(data), .GO(go),
        .END(end_o), .ACK(ack_o), .BUSY(busy_o),
        .I2C_SCLK(scl_o), .I2C_SDAT(sda_w)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] bytes;
        logic        ack;
        int          acc_cyc;
    } exp_t;
    exp_t sb_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    always @(posedge clk) cyc++;

    // Bus decoder, slave responder and scoreboard monitor.
    logic       p_scl = 1'b1, p_sda = 1'b1, p_end = 1'b0, stop_seen = 1'b0;
    int         bitcnt = 0, nbytes = 0, rises = 0, starts = 0;
    logic [7:0] cur = 8'd0;
    logic [7:0] dbytes [3];

    always @(negedge clk) begin
        logic s, d;
        exp_t e;
        s = scl_o;
        d = sda_w;
        if (!rst_n) slave_drive = 1'b0;
        if (s && p_scl && p_sda && !d) begin
            starts++;
            bitcnt = 0; nbytes = 0; rises = 0; stop_seen = 1'b0;
        end else if (s && p_scl && !p_sda && d) begin
            stop_seen = 1'b1;
        end
        if (s && !p_scl) begin
            rises++;
            if (bitcnt == 8) begin
                bitcnt = 0;
            end else begin
                cur = {cur[6:0], d};
                bitcnt++;
                if (bitcnt == 8 && nbytes < 3) begin
                    dbytes[nbytes] = cur;
                    nbytes++;
                end
            end
        end
        if (!s && p_scl) begin
            if (bitcnt == 8 && nbytes >= 1 && nbytes <= 3)
                slave_drive = !nack_mask[nbytes-1];
            else
                slave_drive = 1'b0;
        end
        if (end_o && !p_end) begin
            if (sb_q.size() == 0) begin
                check("unexpected_end", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                $display("txn done: bytes %02h %02h %02h ack=%0b", dbytes[0], dbytes[1], dbytes[2], ack_o);
                check("end_latency", cyc - e.acc_cyc, 452);
                check("byte_count", nbytes, 3);
                check("bus_bytes", {8'd0, dbytes[0], dbytes[1], dbytes[2]}, {8'd0, e.bytes});
                check("ack_flag", ack_o, e.ack);
                check("stop_seen", stop_seen, 1);
                check("scl_rises", rises, 28);
            end
        end
        p_end = end_o;
        p_scl = s;
        p_sda = d;
    end

    task automatic start_txn(input logic [23:0] v, input logic [2:0] mask, input logic exp_ack, input bit push);
        nack_mask = mask;
        data = v;
        go = 1'b1;
        if (push) sb_q.push_back('{bytes: v, ack: exp_ack, acc_cyc: cyc + 1});
    endtask

    task automatic wait_end(input string name);
        int n = 0;
        while (!end_o && n < 600) begin
            @(negedge clk);
            n++;
        end
        check(name, end_o, 1);
    endtask

    initial begin
        int s0;
        repeat (3) @(negedge clk);
        check("rst_scl", scl_o, 1);
        check("rst_sda", sda_w, 1);
        check("rst_end", end_o, 0);
        check("rst_ack", ack_o, 0);
        check("rst_busy", busy_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic write, all bytes acknowledged.
        start_txn(24'h340C00, 3'b000, 1'b0, 1'b1);
        @(negedge clk);
        check("busy_after_go", busy_o, 1);
        wait_end("basic_end");
        repeat (5) @(negedge clk);
        check("end_held", end_o, 1);
        check("ack_basic", ack_o, 0);
        go = 1'b0;
        @(negedge clk);
        check("end_falls", end_o, 0);
        check("busy_idle", busy_o, 0);
        @(negedge clk);

        // Second byte NACKed.
        start_txn(24'h34047B, 3'b010, 1'b1, 1'b1);
        wait_end("nack_end");
        go = 1'b0;
        repeat (2) @(negedge clk);
        check("ack_retained", ack_o, 1);
        check("end_clear_nack", end_o, 0);

        // GO held high for a long time: one transaction only.
        s0 = starts;
        start_txn(24'h401A2B, 3'b000, 1'b0, 1'b1);
        @(negedge clk);
        check("ack_cleared", ack_o, 0);
        repeat (2000) @(negedge clk);
        check("single_start", starts - s0, 1);
        check("end_hold_long", end_o, 1);
        go = 1'b0;
        @(negedge clk);
        start_txn(24'h401A2B, 3'b000, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("sda_before_tick", sda_w, 1);
        @(negedge clk);
        check("sda_first_tick", sda_w, 0);
        check("scl_first_tick", scl_o, 1);
        wait_end("second_end");
        go = 1'b0;
        repeat (2) @(negedge clk);

        // Reset abort in slot 10, then a clean transfer.
        start_txn(24'h340C00, 3'b000, 1'b0, 1'b0);
        repeat (170) @(negedge clk);
        check("abort_scl_low", scl_o, 0);
        check("abort_busy", busy_o, 1);
        rst_n = 1'b0;
        go = 1'b0;
        #1;
        check("abort_scl", scl_o, 1);
        check("abort_sda", sda_w, 1);
        check("abort_end", end_o, 0);
        check("abort_ack", ack_o, 0);
        check("abort_busy_low", busy_o, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_no_stop", stop_seen, 0);
        start_txn(24'h401A2B, 3'b000, 1'b0, 1'b1);
        wait_end("post_abort_end");
        go = 1'b0;
        repeat (2) @(negedge clk);

        // GO released early; data changed after acceptance.
        start_txn(24'h340C00, 3'b000, 1'b0, 1'b1);
        repeat (80) @(negedge clk);
        go = 1'b0;
        data = 24'hFFFFFF;
        wait_end("early_end");
        @(negedge clk);
        check("end_one_cycle", end_o, 0);
        check("busy_after_early", busy_o, 0);
        repeat (10) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
